alu_181_nibble_seq: RTL and testbench
=====================================

Name: alu_181_nibble_seq

Overview:
Parametrised, sequential successor to the fixed two-slice 74181 datapath. It processes a WIDTH-bit 74181-style operation one 4-bit slice per clock, passing the ripple carry through a register, so any width that is a multiple of 4 reuses a single slice of logic. It uses a start/busy/done handshake and an optional chained-carry mode for multi-word arithmetic. It sits between the SPI config/status registers and the display path, replacing the hard-wired cascaded ALU instances.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, derived localparam; number of slices processed per operation.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
ena  input  1  clock enable; when 0, all registers hold, including the handshake outputs.
start  input  1  operation request; sampled only in IDLE with ena=1.
chain  input  1  1 = use the stored carry from the previous operation instead of cn.
a  input  WIDTH  operand A, active-high data.
b  input  WIDTH  operand B, active-high data.
s  input  4  74181 function select.
m  input  1  1 = logic mode, 0 = arithmetic mode.
cn  input  1  carry-in, active-low per the 74181 convention (1 = no carry).
f  output  WIDTH  result register.
cn_out  output  1  final carry-out, active-low.
aeqb  output  1  AND of every slice A=B output, i.e. all bits of f are 1.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset values: f=0, cn_out=1, aeqb=0, busy=0, done=0, state=IDLE, slice index=0, stored carry=1 (no carry).
- States: IDLE and RUN.
- IDLE:
  - On an edge with start=1 and ena=1, latch a, b, s and m into internal registers.
  - Latch the carry register from cn when chain=0, or from the stored cn_out when chain=1.
  - Clear the slice index and the aeqb accumulator (set it to 1), set busy=1, and go to RUN.
- RUN, each enabled edge:
  - Apply the 74181 function to slice idx (bits 4*idx+3 : 4*idx) using the registered carry.
  - Write the 4-bit result into f at slice idx. The other slices of f keep their old values until overwritten.
  - carry <= slice cn4; aeqb accumulator <= accumulator AND slice A=B; idx <= idx+1.
- Last slice (idx = NIB-1): go to IDLE, busy=0, done=1 for exactly one enabled cycle. Update cn_out and aeqb from the final carry and accumulator at this same edge.
- Latency: start sampled at edge E0, then slice i is written at edge E(i+1). done and the final outputs are visible after edge E(NIB) and stay stable until the next accepted start.
- start while busy: ignored, with no queueing. start in the cycle where done=1 is accepted (the block is already in IDLE), giving back-to-back throughput of one operation per NIB+1 cycles.
- Operand inputs are don't-care after the start edge, because the latched copies are used.
- ena=0 in mid-operation freezes idx, carry and all outputs; a done pulse stretches while ena=0.
- rst asserted at any time returns every register to its reset value immediately, aborting any operation. The stored chain carry resets to 1.
- Slice function follows the 74181 active-high truth table for all 32 combinations of s and m.
  - With m=1, the carry is ignored for f, but cn4 is still produced per the truth table.
  - WIDTH=4 degenerates to a single-cycle RUN.

Test Plan:
- Add, WIDTH=8: s=1001, m=0, cn=1, a=0x3C, b=0x15 -> after 2 RUN cycles done=1, f=0x51, cn_out=1. Repeat with cn=0 -> f=0x52.
- Carry and chain: a=0xF0, b=0x20 add, cn=1 -> f=0x10, cn_out=0. Next op chain=1, a=0x00, b=0x00 add -> f=0x01, cn_out=1.
- Compare: s=0110, m=0, cn=1, a=b=0x5A -> f=0xFF, aeqb=1. With b=0x5B -> aeqb=0.
- Logic and width: WIDTH=16, m=1, s=0110 (XOR), a=0xAAAA, b=0x0FF0 -> f=0xA55A. Check busy is high for exactly 4 cycles and done pulses once.
- Handshake: start held high continuously -> a new operation begins in each done cycle and busy never drops for more than 1 cycle. Toggle ena=0 for 3 cycles mid-RUN -> same result, with latency extended by 3.
- Reset mid-operation: assert rst after slice 0 -> f=0, busy=0, done=0 asynchronously. Next chain=1 op uses carry=1.

Source files
------------

// File: rtl/alu_181_nibble_seq.sv
// rtl/alu_181_nibble_seq.sv - WIDTH-bit 74181-style ALU evaluated one 4-bit slice per clock
// Ripple carry between slices lives in carry_q; the final carry-out doubles as the chain carry.
module alu_181_nibble_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             chain,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn,
  output logic [WIDTH-1:0] f,
  output logic             cn_out,
  output logic             aeqb,
  output logic             busy,
  output logic             done
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            acc_q;
  logic [WIDTH-1:0] a_q, b_q, f_q;
  logic [3:0]      s_q;
  logic            m_q;
  logic            cn_out_q, aeqb_q, busy_q, done_q;

  logic [IW+1:0]    sh_d;
  logic [3:0]       a_nib_d, b_nib_d, p_d, g_d, nib_d;
  logic [4:0]       sum_d;
  logic             cn4_d, eq_d, last_d;
  logic [WIDTH-1:0] f_d;

  // The 74181 is an adder of two select-gated terms: F = P + G + Cin in arithmetic
  // mode and F = ~(P ^ G) in logic mode; Cn+4 comes from the same sum in both modes.
  always_comb begin
    sh_d    = {idx_q, 2'b00};
    a_nib_d = 4'(a_q >> sh_d);
    b_nib_d = 4'(b_q >> sh_d);
    p_d     = a_nib_d | (b_nib_d & {4{s_q[0]}}) | (~b_nib_d & {4{s_q[1]}});
    g_d     = (a_nib_d & b_nib_d & {4{s_q[3]}}) | (a_nib_d & ~b_nib_d & {4{s_q[2]}});
    sum_d   = {1'b0, p_d} + {1'b0, g_d} + {4'b0000, ~carry_q};
    nib_d   = m_q ? ~(p_d ^ g_d) : sum_d[3:0];
    cn4_d   = ~sum_d[4];
    eq_d    = &nib_d;
    f_d     = (f_q & ~(WIDTH'(4'hF) << sh_d)) | (WIDTH'(nib_d) << sh_d);
    last_d  = (idx_q == IW'(NIB - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      acc_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= 4'h0;
      m_q      <= 1'b0;
      f_q      <= '0;
      cn_out_q <= 1'b1;
      aeqb_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            carry_q <= chain ? cn_out_q : cn;
            idx_q   <= '0;
            acc_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          f_q     <= f_d;
          carry_q <= cn4_d;
          acc_q   <= acc_q & eq_d;
          idx_q   <= idx_q + 1'b1;
          if (last_d) begin
            cn_out_q <= cn4_d;
            aeqb_q   <= acc_q & eq_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f      = f_q;
  assign cn_out = cn_out_q;
  assign aeqb   = aeqb_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_181_nibble_seq.sv
// tb/tb_alu_181_nibble_seq.sv - directed checks of the slice-serial 74181 ALU at WIDTH 8 and 16
module tb_alu_181_nibble_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ena8, start8, chain8, m8, cn8;
  logic [7:0]  a8, b8, f8;
  logic [3:0]  s8;
  logic        cn_out8, aeqb8, busy8, done8;

  logic        ena16, start16, chain16, m16, cn16;
  logic [15:0] a16, b16, f16;
  logic [3:0]  s16;
  logic        cn_out16, aeqb16, busy16, done16;

  int errors = 0;
  int checks = 0;

  alu_181_nibble_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .ena(ena8), .start(start8), .chain(chain8),
    .a(a8), .b(b8), .s(s8), .m(m8), .cn(cn8),
    .f(f8), .cn_out(cn_out8), .aeqb(aeqb8), .busy(busy8), .done(done8)
  );

  alu_181_nibble_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .ena(ena16), .start(start16), .chain(chain16),
    .a(a16), .b(b16), .s(s16), .m(m16), .cn(cn16),
    .f(f16), .cn_out(cn_out16), .aeqb(aeqb16), .busy(busy16), .done(done16)
  );

  // Start one 8-bit op and wait for done; cyc = negedges observed from E0 through done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                     input logic m, input logic cn, input logic ch, output int cyc);
    @(negedge clk);
    a8 = a; b8 = b; s8 = s; m8 = m; cn8 = cn; chain8 = ch; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = 8'hA5; s8 = ~s; m8 = ~m; cn8 = ~cn; chain8 = ~ch;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({f8, cn_out8, aeqb8, busy8, done8} !== {8'h00, 4'b1000}) begin
      errors++;
      $display("FAIL reset8: got f=%h cn_out=%b aeqb=%b busy=%b done=%b, want f=00 cn_out=1 aeqb=0 busy=0 done=0",
               f8, cn_out8, aeqb8, busy8, done8);
    end
    checks++;
    if ({f16, cn_out16, aeqb16, busy16, done16} !== {16'h0000, 4'b1000}) begin
      errors++;
      $display("FAIL reset16: got f=%h cn_out=%b aeqb=%b busy=%b done=%b, want f=0000 1 0 0 0",
               f16, cn_out16, aeqb16, busy16, done16);
    end
  endtask

  task automatic test_add;
    int cyc;
    op8(8'h3C, 8'h15, 4'b1001, 1'b0, 1'b1, 1'b0, cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL add_latency: got %0d want 3", cyc); end
    checks++;
    if (f8 !== 8'h51) begin errors++; $display("FAIL add_nocarry_f: got %h want 51", f8); end
    checks++;
    if (cn_out8 !== 1'b1) begin errors++; $display("FAIL add_nocarry_cn_out: got %b want 1", cn_out8); end
    op8(8'h3C, 8'h15, 4'b1001, 1'b0, 1'b0, 1'b0, cyc);
    checks++;
    if (f8 !== 8'h52) begin errors++; $display("FAIL add_carry_f: got %h want 52", f8); end
  endtask

  task automatic test_chain;
    int cyc;
    op8(8'hF0, 8'h20, 4'b1001, 1'b0, 1'b1, 1'b0, cyc);
    checks++;
    if ({f8, cn_out8} !== {8'h10, 1'b0}) begin
      errors++; $display("FAIL carry_out: got f=%h cn_out=%b want f=10 cn_out=0", f8, cn_out8);
    end
    op8(8'h00, 8'h00, 4'b1001, 1'b0, 1'b1, 1'b1, cyc);
    checks++;
    if ({f8, cn_out8} !== {8'h01, 1'b1}) begin
      errors++; $display("FAIL chain_in: got f=%h cn_out=%b want f=01 cn_out=1", f8, cn_out8);
    end
  endtask

  task automatic test_compare;
    int cyc;
    op8(8'h5A, 8'h5A, 4'b0110, 1'b0, 1'b1, 1'b0, cyc);
    checks++;
    if ({f8, aeqb8, cn_out8} !== {8'hFF, 1'b1, 1'b1}) begin
      errors++; $display("FAIL cmp_equal: got f=%h aeqb=%b cn_out=%b want FF 1 1", f8, aeqb8, cn_out8);
    end
    op8(8'h5A, 8'h5B, 4'b0110, 1'b0, 1'b1, 1'b0, cyc);
    checks++;
    if ({f8, aeqb8} !== {8'hFE, 1'b0}) begin
      errors++; $display("FAIL cmp_differ: got f=%h aeqb=%b want FE 0", f8, aeqb8);
    end
  endtask

  task automatic test_logic16;
    int busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    @(negedge clk);
    a16 = 16'hAAAA; b16 = 16'h0FF0; s16 = 4'b0110; m16 = 1'b1; cn16 = 1'b0; chain16 = 1'b0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'h1234; b16 = 16'hFFFF;
    if (busy16 === 1'b1) busy_cnt++;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (busy16 === 1'b1) busy_cnt++;
      if (done16 === 1'b1) done_cnt++;
    end
    checks++;
    if (f16 !== 16'hA55A) begin errors++; $display("FAIL xor16_f: got %h want A55A", f16); end
    checks++;
    if (busy_cnt !== 4) begin errors++; $display("FAIL xor16_busy: got %0d cycles want 4", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL xor16_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_back_to_back;
    int done_cnt, gap, max_gap;
    logic f_ok;
    done_cnt = 0; gap = 0; max_gap = 0; f_ok = 1'b1;
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h15; s8 = 4'b1001; m8 = 1'b0; cn8 = 1'b1; chain8 = 1'b0; start8 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        done_cnt++;
        if (f8 !== 8'h51) f_ok = 1'b0;
      end
      if (busy8 === 1'b1) gap = 0;
      else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
    end
    start8 = 1'b0;
    checks++;
    if (done_cnt !== 4) begin errors++; $display("FAIL b2b_done_count: got %0d want 4", done_cnt); end
    checks++;
    if (max_gap !== 1) begin errors++; $display("FAIL b2b_idle_gap: got %0d want 1", max_gap); end
    checks++;
    if (f_ok !== 1'b1) begin errors++; $display("FAIL b2b_result: got a result other than 51 at a done, want 51"); end
  endtask

  task automatic test_ena_stall;
    int cyc;
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h15; s8 = 4'b1001; m8 = 1'b0; cn8 = 1'b1; chain8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    cyc = 1;
    @(negedge clk);
    cyc++;
    ena8 = 1'b0;
    repeat (3) begin @(negedge clk); cyc++; end
    ena8 = 1'b1;
    while (done8 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 6) begin errors++; $display("FAIL stall_latency: got %0d want 6", cyc); end
    checks++;
    if (f8 !== 8'h51) begin errors++; $display("FAIL stall_f: got %h want 51", f8); end
    ena8 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done8 !== 1'b1) begin errors++; $display("FAIL done_stretch: got %b want 1", done8); end
    ena8 = 1'b1;
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin errors++; $display("FAIL done_release: got %b want 0", done8); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    op8(8'hF0, 8'h20, 4'b1001, 1'b0, 1'b1, 1'b0, cyc);
    checks++;
    if (cn_out8 !== 1'b0) begin errors++; $display("FAIL pre_reset_cn_out: got %b want 0", cn_out8); end
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; s8 = 4'b1001; m8 = 1'b0; cn8 = 1'b1; chain8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({f8, cn_out8, busy8, done8} !== {8'h00, 3'b100}) begin
      errors++; $display("FAIL reset_mid: got f=%h cn_out=%b busy=%b done=%b want 00 1 0 0",
                         f8, cn_out8, busy8, done8);
    end
    @(negedge clk);
    rst = 1'b0;
    op8(8'h00, 8'h00, 4'b1001, 1'b0, 1'b0, 1'b1, cyc);
    checks++;
    if ({f8, cn_out8} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL chain_after_reset: got f=%h cn_out=%b want 00 1", f8, cn_out8);
    end
  endtask

  initial begin
    rst = 1'b1;
    ena8 = 1'b1; start8 = 1'b0; chain8 = 1'b0; m8 = 1'b0; cn8 = 1'b1;
    a8 = 8'h00; b8 = 8'h00; s8 = 4'h0;
    ena16 = 1'b1; start16 = 1'b0; chain16 = 1'b0; m16 = 1'b0; cn16 = 1'b1;
    a16 = 16'h0000; b16 = 16'h0000; s16 = 4'h0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_add;
    test_chain;
    test_compare;
    test_logic16;
    test_back_to_back;
    test_ena_stall;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
